// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: shared FSM state encoding and line-level constants for the frame receiver.
package serial_frame_rx_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial input, output handshake and status signals of the frame receiver.
//   master: drives ser_in/bit_en/out_ready/clr_ovr, observes the received word and status.
//   slave : the receiver side.
interface serial_frame_rx_if #(parameter int W = 4);
    logic         ser_in, bit_en, out_ready, clr_ovr;
    logic         out_valid, out_perr, out_ferr, overrun, busy;
    logic [W-1:0] out_data;
    modport master(output ser_in, bit_en, out_ready, clr_ovr,
                   input out_valid, out_data, out_perr, out_ferr, overrun, busy);
    modport slave(input ser_in, bit_en, out_ready, clr_ovr,
                  output out_valid, out_data, out_perr, out_ferr, overrun, busy);
endinterface

// File: rtl/serial_frame_rx_out_reg.sv
// rx_out_reg: valid/ready holding register for a received word plus parity/framing tags, with sticky overrun.
//   i_load : a frame completes this cycle    i_ready/o_valid : consumer handshake
//   i_clr  : clears sticky overrun           o_ovr : a completed word was dropped
module rx_out_reg #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_perr,
    input  logic         i_ferr,
    input  logic         i_ready,
    input  logic         i_clr,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_perr,
    output logic         o_ferr,
    output logic         o_ovr
);
    logic         r_valid, r_perr, r_ferr, r_ovr;
    logic [W-1:0] r_data;
    logic         w_acc;
    // A word is taken if the slot is empty or being popped in the same cycle.
    assign w_acc = i_load && (!r_valid || i_ready);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= w_acc || (r_valid && !i_ready);
            if (w_acc) {r_data, r_perr, r_ferr} <= {i_data, i_perr, i_ferr};
            r_ovr <= (i_load && !w_acc) || (r_ovr && !i_clr);
        end
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_perr  = r_perr;
    assign o_ferr  = r_ferr;
    assign o_ovr   = r_ovr;
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: LSB-first serial frame deserializer (start, W data, optional even parity, stop).
//   clk/rst : clock, async active-high reset
//   bus     : ser_in/bit_en in, out_valid/out_ready word handshake, perr/ferr tags, overrun, busy
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int W         = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    serial_frame_rx_if.slave bus
);
    localparam int CW = $clog2(W);
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_asm;
    logic          r_perr;
    logic          w_last, w_done;
    assign w_last = r_cnt == CW'(W - 1);
    assign w_done = bus.bit_en && r_state == STOP;
    always_comb begin
        w_next = r_state;
        if (bus.bit_en)
            w_next = r_state == IDLE   ? (bus.ser_in == START_BIT ? DATA : IDLE) :
                     r_state == DATA   ? (w_last ? (PARITY_EN ? PARITY : STOP) : DATA) :
                     r_state == PARITY ? STOP : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_perr  <= 1'b0;
        end else if (bus.bit_en) begin
            r_state <= w_next;
            if (r_state == IDLE) r_cnt <= '0;
            if (r_state == DATA) begin
                r_asm <= {bus.ser_in, r_asm[W-1:1]};
                // Hold at terminal count; the start bit re-zeroes it.
                if (!w_last) r_cnt <= r_cnt + 1'b1;
            end
            // 1 when data plus parity bit hold an odd number of ones.
            if (r_state == PARITY) r_perr <= ^r_asm ^ bus.ser_in;
        end
    end
    assign bus.busy = r_state != IDLE;
    rx_out_reg #(.W(W)) u_out (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_done),
        .i_data (r_asm),
        .i_perr (r_perr),
        .i_ferr (bus.ser_in != STOP_BIT),
        .i_ready(bus.out_ready),
        .i_clr  (bus.clr_ovr),
        .o_valid(bus.out_valid),
        .o_data (bus.out_data),
        .o_perr (bus.out_perr),
        .o_ferr (bus.out_ferr),
        .o_ovr  (bus.overrun)
    );
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: randomized and directed checks of serial_frame_rx against frame-level expectations.
module tb_serial_frame_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    always #5 clk = ~clk;
    serial_frame_rx_if #(.W(4)) b0 ();
    serial_frame_rx_if #(.W(4)) b1 ();
    serial_frame_rx #(.W(4), .PARITY_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    serial_frame_rx #(.W(4), .PARITY_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic bit0(input logic b, input logic en);
        b0.ser_in = b;
        b0.bit_en = en;
        @(posedge clk);
        #1;
    endtask

    // Frame on the wire: start, d LSB first, parity bit p, stop bit s; out_ready=rdy on the stop bit.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input logic rdy);
        bit0(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) bit0(d[i], 1'b1);
        bit0(p, 1'b1);
        b0.out_ready = rdy;
        bit0(s, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr, b0.overrun, b0.busy} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want %b",
                     {b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr, b0.overrun, b0.busy}, 9'b0);
        end
        n_tests++;
        if ({b1.out_valid, b1.busy, b1.overrun} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_noparity: got %b, want 000", {b1.out_valid, b1.busy, b1.overrun});
        end
        rst = 1'b0;
        bit0(1'b1, 1'b1);
    endtask

    task automatic test_basic;
        b0.out_ready = 1'b1;
        bit0(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) bit0(i[0], 1'b1);
        bit0(1'b0, 1'b1);
        n_tests++;
        if (b0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b, want 0", b0.out_valid);
        end
        bit0(1'b1, 1'b1);
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr} !== {1'b1, 4'hA, 2'b00}) begin
            n_fail++;
            $display("FAIL basic_word: got %b, want %b",
                     {b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr}, {1'b1, 4'hA, 2'b00});
        end
        bit0(1'b1, 1'b1);
        n_tests++;
        if (b0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: got %b, want 0", b0.out_valid);
        end
    endtask

    task automatic test_errors;
        b0.out_ready = 1'b1;
        send_frame(4'hA, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr} !== {1'b1, 4'hA, 2'b10}) begin
            n_fail++;
            $display("FAIL parity_err: got %b, want %b",
                     {b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr}, {1'b1, 4'hA, 2'b10});
        end
        bit0(1'b1, 1'b1);
        send_frame(4'hA, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr} !== {1'b1, 4'hA, 2'b01}) begin
            n_fail++;
            $display("FAIL frame_err: got %b, want %b",
                     {b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr}, {1'b1, 4'hA, 2'b01});
        end
        bit0(1'b1, 1'b1);
    endtask

    task automatic test_overrun;
        b0.out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.overrun} !== {1'b1, 4'h3, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_hold: got %b, want %b", {b0.out_valid, b0.out_data, b0.overrun},
                     {1'b1, 4'h3, 1'b1});
        end
        b0.clr_ovr = 1'b1;
        bit0(1'b1, 1'b0);
        b0.clr_ovr = 1'b0;
        n_tests++;
        if ({b0.overrun, b0.out_data} !== {1'b0, 4'h3}) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b, want %b", {b0.overrun, b0.out_data}, {1'b0, 4'h3});
        end
        send_frame(4'h5, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.overrun} !== {1'b1, 4'h5, 1'b0}) begin
            n_fail++;
            $display("FAIL pop_reload: got %b, want %b", {b0.out_valid, b0.out_data, b0.overrun},
                     {1'b1, 4'h5, 1'b0});
        end
        bit0(1'b1, 1'b1);
        n_tests++;
        if (b0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got %b, want 0", b0.out_valid);
        end
    endtask

    task automatic test_bit_en;
        logic seq[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   busy_bad = 0;
        b0.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit0(1'b1, 1'b1);
            if (b0.busy !== 1'b0) busy_bad++;
        end
        n_tests++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL idle_busy: got %0d busy cycles, want 0", busy_bad);
        end
        for (int k = 0; k < 7; k++) begin
            bit0(seq[k], 1'b1);
            if (k < 6) begin
                bit0(1'($urandom_range(0, 1)), 1'b0);
                n_tests++;
                if ({b0.busy, b0.out_valid} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL freeze_bit%0d: got busy/valid %b, want 10", k, {b0.busy, b0.out_valid});
                end
            end
        end
        n_tests++;
        if ({b0.busy, b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr} !== {2'b01, 4'hC, 2'b00}) begin
            n_fail++;
            $display("FAIL gated_word: got %b, want %b",
                     {b0.busy, b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr}, {2'b01, 4'hC, 2'b00});
        end
        bit0(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid;
        b0.out_ready = 1'b0;
        send_frame(4'h9, 1'b0, 1'b1, 1'b0);
        bit0(1'b0, 1'b1);
        bit0(1'b1, 1'b1);
        bit0(1'b0, 1'b1);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({b0.busy, b0.out_valid, b0.out_data, b0.overrun} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, want %b", {b0.busy, b0.out_valid, b0.out_data, b0.overrun}, 7'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        b0.out_ready = 1'b1;
        bit0(1'b1, 1'b1);
        send_frame(4'h6, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if ({b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr} !== {1'b1, 4'h6, 2'b00}) begin
            n_fail++;
            $display("FAIL after_reset: got %b, want %b",
                     {b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr}, {1'b1, 4'h6, 2'b00});
        end
        bit0(1'b1, 1'b1);
    endtask

    // Random words, parity/stop correctness and bit_en gaps; expected tags from parity arithmetic.
    task automatic test_random;
        b0.out_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [3:0] d = 4'($urandom_range(0, 15));
            logic       p = 1'($urandom_range(0, 1));
            logic       s = $urandom_range(0, 3) != 0;
            logic       bits[7];
            logic [6:0] want;
            bits[0] = 1'b0;
            for (int i = 0; i < 4; i++) bits[i+1] = d[i];
            bits[5] = p;
            bits[6] = s;
            want = {1'b1, d, 1'((($countones(d) + int'(p)) % 2)), ~s};
            for (int i = 0; i < 7; i++) begin
                repeat ($urandom_range(0, 2)) bit0(1'($urandom_range(0, 1)), 1'b0);
                bit0(bits[i], 1'b1);
            end
            n_tests++;
            if ({b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr} !== want) begin
                n_fail++;
                $display("FAIL random_frame%0d: got %b, want %b", f,
                         {b0.out_valid, b0.out_data, b0.out_perr, b0.out_ferr}, want);
            end
            repeat ($urandom_range(0, 2)) bit0(1'b1, 1'b1);
        end
        n_tests++;
        if (b0.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL random_overrun: got %b, want 0", b0.overrun);
        end
    endtask

    task automatic test_noparity;
        logic seq[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            b1.ser_in = seq[k];
            b1.bit_en = 1'b1;
            @(posedge clk);
            #1;
            if (k == 4) begin
                n_tests++;
                if (b1.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL noparity_early: got %b, want 0", b1.out_valid);
                end
            end
        end
        n_tests++;
        if ({b1.out_valid, b1.out_data, b1.out_perr, b1.out_ferr} !== {1'b1, 4'hF, 2'b00}) begin
            n_fail++;
            $display("FAIL noparity_word: got %b, want %b",
                     {b1.out_valid, b1.out_data, b1.out_perr, b1.out_ferr}, {1'b1, 4'hF, 2'b00});
        end
    endtask

    initial begin
        b0.ser_in = 1'b1; b0.bit_en = 1'b0; b0.out_ready = 1'b1; b0.clr_ovr = 1'b0;
        b1.ser_in = 1'b1; b1.bit_en = 1'b0; b1.out_ready = 1'b1; b1.clr_ovr = 1'b0;
        test_reset;
        test_basic;
        test_errors;
        test_overrun;
        test_bit_en;
        test_reset_mid;
        test_random;
        test_noparity;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
